pspin_tx_merge: RTL and testbench

PSPIN_TX_MERGE -- requirements
Module: pspin_tx_merge

---
 rtl/pspin_pkt_pkg.sv | 33 +++
 rtl/pspin_axis_reg.sv | 78 +++++++
 rtl/pspin_tx_merge.sv | 153 +++++++++++++++
 tb/tb_pspin_tx_merge.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pspin_pkt_pkg.sv
// ============================================================================
// Module  : pspin_pkt_pkg
// Brief   : Shared packet-path types: TX merge states, source ids, RX match modes.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package pspin_pkt_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    XFER_NIC   = 2'd1,
    XFER_PSPIN = 2'd2
  } tx_state_e;

  localparam logic SRC_NIC   = 1'b0;
  localparam logic SRC_PSPIN = 1'b1;

  localparam logic [1:0] MATCH_MODE_AND  = 2'd0;
  localparam logic [1:0] MATCH_MODE_OR   = 2'd1;
  localparam logic [1:0] MATCH_MODE_NONE = 2'd2;

  // Strict mode favours PsPIN; round-robin gives a tie to the source opposite last_src.
  function automatic logic tx_arb_pick(input logic nic_valid, input logic pspin_valid,
                                       input logic strict, input logic last_src);
    if (pspin_valid && (strict || !nic_valid || last_src == SRC_NIC))
      return SRC_PSPIN;
    return SRC_NIC;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pspin_axis_reg.sv
// ============================================================================
// Module  : pspin_axis_reg
// Brief   : Single-stage AXI-Stream register slice with valid/ready handshake.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module pspin_axis_reg #(
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 1,
  parameter int DEST_WIDTH = 8,
  parameter int USER_WIDTH = 17
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DATA_WIDTH-1:0] i_s_tdata,
  input  logic [KEEP_WIDTH-1:0] i_s_tkeep,
  input  logic                  i_s_tvalid,
  output logic                  o_s_tready,
  input  logic                  i_s_tlast,
  input  logic [ID_WIDTH-1:0]   i_s_tid,
  input  logic [DEST_WIDTH-1:0] i_s_tdest,
  input  logic [USER_WIDTH-1:0] i_s_tuser,
  output logic [DATA_WIDTH-1:0] o_m_tdata,
  output logic [KEEP_WIDTH-1:0] o_m_tkeep,
  output logic                  o_m_tvalid,
  input  logic                  i_m_tready,
  output logic                  o_m_tlast,
  output logic [ID_WIDTH-1:0]   o_m_tid,
  output logic [DEST_WIDTH-1:0] o_m_tdest,
  output logic [USER_WIDTH-1:0] o_m_tuser
);

  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;
  logic [KEEP_WIDTH-1:0] r_keep;
  logic                  r_last;
  logic [ID_WIDTH-1:0]   r_id;
  logic [DEST_WIDTH-1:0] r_dest;
  logic [USER_WIDTH-1:0] r_user;

  // Accept when empty or when the held beat drains this cycle.
  assign o_s_tready = !r_valid || i_m_tready;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_keep  <= '0;
      r_last  <= 1'b0;
      r_id    <= '0;
      r_dest  <= '0;
      r_user  <= '0;
    end else if (o_s_tready) begin
      r_valid <= i_s_tvalid;
      if (i_s_tvalid) begin
        r_data <= i_s_tdata;
        r_keep <= i_s_tkeep;
        r_last <= i_s_tlast;
        r_id   <= i_s_tid;
        r_dest <= i_s_tdest;
        r_user <= i_s_tuser;
      end
    end
  end

  assign o_m_tvalid = r_valid;
  assign o_m_tdata  = r_data;
  assign o_m_tkeep  = r_keep;
  assign o_m_tlast  = r_last;
  assign o_m_tid    = r_id;
  assign o_m_tdest  = r_dest;
  assign o_m_tuser  = r_user;

endmodule

`default_nettype wire

// File: rtl/pspin_tx_merge.sv
// ============================================================================
// Module  : pspin_tx_merge
// Brief   : Frame-atomic merge of host TX and PsPIN egress streams onto the MAC.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module pspin_tx_merge
  import pspin_pkt_pkg::*;
#(
  parameter int AXIS_IF_DATA_WIDTH    = 512,
  parameter int AXIS_IF_KEEP_WIDTH    = AXIS_IF_DATA_WIDTH / 8,
  parameter int AXIS_IF_TX_ID_WIDTH   = 1,
  parameter int AXIS_IF_TX_DEST_WIDTH = 8,
  parameter int AXIS_IF_TX_USER_WIDTH = 17
) (
  input  logic                             clk,
  input  logic                             rstn,

  input  logic [AXIS_IF_DATA_WIDTH-1:0]    s_axis_nic_tx_tdata,
  input  logic [AXIS_IF_KEEP_WIDTH-1:0]    s_axis_nic_tx_tkeep,
  input  logic                             s_axis_nic_tx_tvalid,
  output logic                             s_axis_nic_tx_tready,
  input  logic                             s_axis_nic_tx_tlast,
  input  logic [AXIS_IF_TX_ID_WIDTH-1:0]   s_axis_nic_tx_tid,
  input  logic [AXIS_IF_TX_DEST_WIDTH-1:0] s_axis_nic_tx_tdest,
  input  logic [AXIS_IF_TX_USER_WIDTH-1:0] s_axis_nic_tx_tuser,

  input  logic [AXIS_IF_DATA_WIDTH-1:0]    s_axis_pspin_tx_tdata,
  input  logic [AXIS_IF_KEEP_WIDTH-1:0]    s_axis_pspin_tx_tkeep,
  input  logic                             s_axis_pspin_tx_tvalid,
  output logic                             s_axis_pspin_tx_tready,
  input  logic                             s_axis_pspin_tx_tlast,
  input  logic [AXIS_IF_TX_ID_WIDTH-1:0]   s_axis_pspin_tx_tid,
  input  logic [AXIS_IF_TX_DEST_WIDTH-1:0] s_axis_pspin_tx_tdest,
  input  logic [AXIS_IF_TX_USER_WIDTH-1:0] s_axis_pspin_tx_tuser,

  output logic [AXIS_IF_DATA_WIDTH-1:0]    m_axis_tx_tdata,
  output logic [AXIS_IF_KEEP_WIDTH-1:0]    m_axis_tx_tkeep,
  output logic                             m_axis_tx_tvalid,
  input  logic                             m_axis_tx_tready,
  output logic                             m_axis_tx_tlast,
  output logic [AXIS_IF_TX_ID_WIDTH-1:0]   m_axis_tx_tid,
  output logic [AXIS_IF_TX_DEST_WIDTH-1:0] m_axis_tx_tdest,
  output logic [AXIS_IF_TX_USER_WIDTH-1:0] m_axis_tx_tuser,

  input  logic                             arb_mode,
  output logic [31:0]                      stat_nic_frames,
  output logic [31:0]                      stat_pspin_frames,
  output logic                             busy
);

  tx_state_e   r_state;
  logic        r_last_src;
  logic        r_busy;
  logic [31:0] r_stat_nic_frames;
  logic [31:0] r_stat_pspin_frames;

  logic        w_out_ready;
  logic        w_grant_valid;
  logic        w_src;
  logic        w_sel_valid;
  logic        w_sel_last;
  logic        w_fire;

  // Grant is recomputed every cycle in IDLE; in XFER_x it is pinned to the frame owner.
  always_comb begin
    w_grant_valid = 1'b0;
    w_src         = SRC_NIC;
    case (r_state)
      IDLE: begin
        w_grant_valid = s_axis_nic_tx_tvalid || s_axis_pspin_tx_tvalid;
        w_src         = tx_arb_pick(s_axis_nic_tx_tvalid, s_axis_pspin_tx_tvalid,
                                    arb_mode, r_last_src);
      end
      XFER_NIC: begin
        w_grant_valid = 1'b1;
        w_src         = SRC_NIC;
      end
      XFER_PSPIN: begin
        w_grant_valid = 1'b1;
        w_src         = SRC_PSPIN;
      end
      default: begin
        w_grant_valid = 1'b0;
        w_src         = SRC_NIC;
      end
    endcase
  end

  assign s_axis_nic_tx_tready   = rstn && w_out_ready && w_grant_valid && (w_src == SRC_NIC);
  assign s_axis_pspin_tx_tready = rstn && w_out_ready && w_grant_valid && (w_src == SRC_PSPIN);

  assign w_sel_valid = (w_src == SRC_PSPIN) ? s_axis_pspin_tx_tvalid : s_axis_nic_tx_tvalid;
  assign w_sel_last  = (w_src == SRC_PSPIN) ? s_axis_pspin_tx_tlast  : s_axis_nic_tx_tlast;
  assign w_fire      = w_sel_valid &&
                       ((w_src == SRC_PSPIN) ? s_axis_pspin_tx_tready : s_axis_nic_tx_tready);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state             <= IDLE;
      r_last_src          <= SRC_PSPIN;
      r_busy              <= 1'b0;
      r_stat_nic_frames   <= '0;
      r_stat_pspin_frames <= '0;
    end else if (w_fire) begin
      if (w_sel_last) begin
        r_state    <= IDLE;
        r_busy     <= 1'b0;
        r_last_src <= w_src;
        if (w_src == SRC_NIC) r_stat_nic_frames   <= r_stat_nic_frames + 32'd1;
        else                  r_stat_pspin_frames <= r_stat_pspin_frames + 32'd1;
      end else begin
        r_state <= (w_src == SRC_NIC) ? XFER_NIC : XFER_PSPIN;
        r_busy  <= 1'b1;
      end
    end
  end

  pspin_axis_reg #(
    .DATA_WIDTH (AXIS_IF_DATA_WIDTH),
    .KEEP_WIDTH (AXIS_IF_KEEP_WIDTH),
    .ID_WIDTH   (AXIS_IF_TX_ID_WIDTH),
    .DEST_WIDTH (AXIS_IF_TX_DEST_WIDTH),
    .USER_WIDTH (AXIS_IF_TX_USER_WIDTH)
  ) u_out_reg (
    .clk        (clk),
    .rstn       (rstn),
    .i_s_tdata  ((w_src == SRC_PSPIN) ? s_axis_pspin_tx_tdata : s_axis_nic_tx_tdata),
    .i_s_tkeep  ((w_src == SRC_PSPIN) ? s_axis_pspin_tx_tkeep : s_axis_nic_tx_tkeep),
    .i_s_tvalid (w_fire),
    .o_s_tready (w_out_ready),
    .i_s_tlast  (w_sel_last),
    .i_s_tid    ((w_src == SRC_PSPIN) ? s_axis_pspin_tx_tid   : s_axis_nic_tx_tid),
    .i_s_tdest  ((w_src == SRC_PSPIN) ? s_axis_pspin_tx_tdest : s_axis_nic_tx_tdest),
    .i_s_tuser  ((w_src == SRC_PSPIN) ? s_axis_pspin_tx_tuser : s_axis_nic_tx_tuser),
    .o_m_tdata  (m_axis_tx_tdata),
    .o_m_tkeep  (m_axis_tx_tkeep),
    .o_m_tvalid (m_axis_tx_tvalid),
    .i_m_tready (m_axis_tx_tready),
    .o_m_tlast  (m_axis_tx_tlast),
    .o_m_tid    (m_axis_tx_tid),
    .o_m_tdest  (m_axis_tx_tdest),
    .o_m_tuser  (m_axis_tx_tuser)
  );

  assign stat_nic_frames   = r_stat_nic_frames;
  assign stat_pspin_frames = r_stat_pspin_frames;
  assign busy              = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_pspin_tx_merge.sv
// ============================================================================
// Module  : tb_pspin_tx_merge
// Brief   : Directed self-checking bench for the TX merge arbiter.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pspin_tx_merge;

  localparam int DW = 64;
  localparam int KW = 8;
  localparam int IW = 1;
  localparam int SW = 8;
  localparam int UW = 17;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic [IW-1:0] id;
    logic [SW-1:0] dest;
    logic [UW-1:0] user;
  } beat_t;

  logic          clk = 1'b0;
  logic          rstn;
  logic [DW-1:0] nic_tdata, psp_tdata, m_tdata;
  logic [KW-1:0] nic_tkeep, psp_tkeep, m_tkeep;
  logic          nic_tvalid, psp_tvalid, m_tvalid;
  logic          nic_tready, psp_tready, m_tready;
  logic          nic_tlast, psp_tlast, m_tlast;
  logic [IW-1:0] nic_tid, psp_tid, m_tid;
  logic [SW-1:0] nic_tdest, psp_tdest, m_tdest;
  logic [UW-1:0] nic_tuser, psp_tuser, m_tuser;
  logic          arb_mode;
  logic [31:0]   stat_nic, stat_psp;
  logic          busy;

  always #5 clk = ~clk;

  pspin_tx_merge #(
    .AXIS_IF_DATA_WIDTH    (DW),
    .AXIS_IF_KEEP_WIDTH    (KW),
    .AXIS_IF_TX_ID_WIDTH   (IW),
    .AXIS_IF_TX_DEST_WIDTH (SW),
    .AXIS_IF_TX_USER_WIDTH (UW)
  ) dut (
    .clk                    (clk),
    .rstn                   (rstn),
    .s_axis_nic_tx_tdata    (nic_tdata),
    .s_axis_nic_tx_tkeep    (nic_tkeep),
    .s_axis_nic_tx_tvalid   (nic_tvalid),
    .s_axis_nic_tx_tready   (nic_tready),
    .s_axis_nic_tx_tlast    (nic_tlast),
    .s_axis_nic_tx_tid      (nic_tid),
    .s_axis_nic_tx_tdest    (nic_tdest),
    .s_axis_nic_tx_tuser    (nic_tuser),
    .s_axis_pspin_tx_tdata  (psp_tdata),
    .s_axis_pspin_tx_tkeep  (psp_tkeep),
    .s_axis_pspin_tx_tvalid (psp_tvalid),
    .s_axis_pspin_tx_tready (psp_tready),
    .s_axis_pspin_tx_tlast  (psp_tlast),
    .s_axis_pspin_tx_tid    (psp_tid),
    .s_axis_pspin_tx_tdest  (psp_tdest),
    .s_axis_pspin_tx_tuser  (psp_tuser),
    .m_axis_tx_tdata        (m_tdata),
    .m_axis_tx_tkeep        (m_tkeep),
    .m_axis_tx_tvalid       (m_tvalid),
    .m_axis_tx_tready       (m_tready),
    .m_axis_tx_tlast        (m_tlast),
    .m_axis_tx_tid          (m_tid),
    .m_axis_tx_tdest        (m_tdest),
    .m_axis_tx_tuser        (m_tuser),
    .arb_mode               (arb_mode),
    .stat_nic_frames        (stat_nic),
    .stat_pspin_frames      (stat_psp),
    .busy                   (busy)
  );

  int    n_chk = 0;
  int    n_bad = 0;
  int    cyc   = 0;
  int    n_stall_chk = 0;
  logic  drv_en = 1'b0;
  logic  chk_nic_idle = 1'b0;
  logic  nic_hs = 1'b0, psp_hs = 1'b0;
  logic  prev_stall = 1'b0;
  beat_t prev_out;
  beat_t nic_q[$], psp_q[$];
  beat_t in_log[$], out_log[$];
  int    in_cyc[$], out_cyc[$];

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic beat_t mk_beat(input int src, input int frame, input int beat, input int n);
    beat_t b;
    b.data = (64'(src) << 56) | (64'(frame) << 16) | 64'(beat);
    b.keep = '1;
    b.last = (beat == n - 1);
    b.id   = IW'(src);
    b.dest = SW'(frame);
    b.user = UW'(beat * 3 + src);
    return b;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Source drivers and MAC monitor; handshakes are sampled just before each rising edge.
  always begin
    @(negedge clk);
    if (drv_en) begin
      if (nic_hs && nic_q.size() > 0) nic_q.delete(0);
      if (psp_hs && psp_q.size() > 0) psp_q.delete(0);
      if (nic_q.size() > 0) begin
        nic_tvalid = 1'b1;
        {nic_tdata, nic_tkeep, nic_tlast, nic_tid, nic_tdest, nic_tuser} = nic_q[0];
      end else nic_tvalid = 1'b0;
      if (psp_q.size() > 0) begin
        psp_tvalid = 1'b1;
        {psp_tdata, psp_tkeep, psp_tlast, psp_tid, psp_tdest, psp_tuser} = psp_q[0];
      end else psp_tvalid = 1'b0;
    end
    #4;
    nic_hs = nic_tvalid && nic_tready;
    psp_hs = psp_tvalid && psp_tready;
    if (nic_hs) begin
      in_log.push_back({nic_tdata, nic_tkeep, nic_tlast, nic_tid, nic_tdest, nic_tuser});
      in_cyc.push_back(cyc);
    end
    if (psp_hs) begin
      in_log.push_back({psp_tdata, psp_tkeep, psp_tlast, psp_tid, psp_tdest, psp_tuser});
      in_cyc.push_back(cyc);
    end
    if (chk_nic_idle && psp_tvalid) check_val("bp_nic_tready", nic_tready, 1'b0);
    if (prev_stall) begin
      n_stall_chk++;
      check_val("stall_hold", {m_tvalid, m_tdata, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser},
                {1'b1, prev_out});
    end
    prev_stall = m_tvalid && !m_tready;
    prev_out   = {m_tdata, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser};
    if (m_tvalid && m_tready) begin
      out_log.push_back({m_tdata, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser});
      out_cyc.push_back(cyc);
    end
  end

  task automatic clear_logs();
    in_log.delete();
    in_cyc.delete();
    out_log.delete();
    out_cyc.delete();
  endtask

  task automatic wait_out(input int n, input string tag);
    int k = 0;
    while (out_log.size() < n && k < 200) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    check_val({tag, "_beat_count"}, out_log.size(), n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    beat_t b;
    int    k;
    rstn = 1'b0; m_tready = 1'b1; arb_mode = 1'b0;
    {nic_tdata, nic_tkeep, nic_tlast, nic_tid, nic_tdest, nic_tuser} = '0;
    {psp_tdata, psp_tkeep, psp_tlast, psp_tid, psp_tdest, psp_tuser} = '0;
    nic_tvalid = 1'b1; psp_tvalid = 1'b1;

    // Reset state with both sources requesting.
    repeat (3) @(negedge clk);
    #4;
    check_val("rst_nic_tready", nic_tready, 1'b0);
    check_val("rst_psp_tready", psp_tready, 1'b0);
    check_val("rst_m_tvalid", m_tvalid, 1'b0);
    check_val("rst_m_tlast", m_tlast, 1'b0);
    check_val("rst_m_fields", {m_tdata, m_tkeep, m_tid, m_tdest, m_tuser}, '0);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_stats", {stat_nic, stat_psp}, '0);
    @(negedge clk);
    nic_tvalid = 1'b0; psp_tvalid = 1'b0; rstn = 1'b1; drv_en = 1'b1;
    @(negedge clk);

    // Round-robin tie after reset: NIC first.
    clear_logs();
    for (int i = 0; i < 3; i++) begin
      nic_q.push_back(mk_beat(0, 1, i, 3));
      psp_q.push_back(mk_beat(1, 1, i, 3));
    end
    wait_out(6, "rr");
    for (int i = 0; i < 3; i++) begin
      check_val("rr_nic_beat", out_log[i], mk_beat(0, 1, i, 3));
      check_val("rr_psp_beat", out_log[i+3], mk_beat(1, 1, i, 3));
    end
    for (int i = 1; i < 6; i++) check_val("rr_no_gap", out_cyc[i] - out_cyc[0], i);
    check_val("rr_stat_nic", stat_nic, 32'd1);
    check_val("rr_stat_psp", stat_psp, 32'd1);

    // Strict priority: both PsPIN frames before any NIC frame.
    clear_logs();
    arb_mode = 1'b1;
    for (int f = 0; f < 4; f++)
      for (int i = 0; i < 2; i++) nic_q.push_back(mk_beat(0, 10 + f, i, 2));
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 2; i++) psp_q.push_back(mk_beat(1, 20 + f, i, 2));
    wait_out(12, "prio");
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 2; i++)
        check_val("prio_psp_beat", out_log[f*2+i], mk_beat(1, 20 + f, i, 2));
    for (int f = 0; f < 4; f++)
      for (int i = 0; i < 2; i++)
        check_val("prio_nic_beat", out_log[4+f*2+i], mk_beat(0, 10 + f, i, 2));
    check_val("prio_stat_nic", stat_nic, 32'd5);
    check_val("prio_stat_psp", stat_psp, 32'd3);

    // Backpressure on a 5-beat PsPIN frame while a NIC frame waits.
    clear_logs();
    arb_mode = 1'b0;
    n_stall_chk = 0;
    for (int i = 0; i < 5; i++) psp_q.push_back(mk_beat(1, 3, i, 5));
    nic_q.push_back(mk_beat(0, 3, 0, 1));
    chk_nic_idle = 1'b1;
    begin
      logic [7:0] rdy_pat;
      rdy_pat = 8'b1101_1001;
      for (int c = 0; c < 8; c++) begin
        m_tready = rdy_pat[c];
        @(negedge clk);
      end
    end
    m_tready = 1'b1;
    wait_out(6, "bp");
    chk_nic_idle = 1'b0;
    for (int i = 0; i < 5; i++) check_val("bp_psp_beat", out_log[i], mk_beat(1, 3, i, 5));
    check_val("bp_nic_after", out_log[5], mk_beat(0, 3, 0, 1));
    check_val("bp_stalls_seen", n_stall_chk > 0, 1'b1);
    check_val("bp_stats", {stat_nic, stat_psp}, {32'd6, 32'd4});

    // Alternating single-beat frames, one with an empty keep.
    clear_logs();
    for (int f = 0; f < 3; f++) begin
      psp_q.push_back(mk_beat(1, 4 + f, 0, 1));
      b = mk_beat(0, 4 + f, 0, 1);
      if (f == 1) b.keep = '0;
      nic_q.push_back(b);
    end
    wait_out(6, "single");
    for (int f = 0; f < 3; f++) begin
      check_val("single_psp", out_log[2*f], mk_beat(1, 4 + f, 0, 1));
      b = mk_beat(0, 4 + f, 0, 1);
      if (f == 1) b.keep = '0;
      check_val("single_nic", out_log[2*f+1], b);
    end
    for (int i = 0; i < 6; i++) begin
      check_val("single_latency", out_cyc[i] - in_cyc[i], 1);
      check_val("single_rate", out_cyc[i] - out_cyc[0], i);
    end
    check_val("single_stats", {stat_nic, stat_psp}, {32'd9, 32'd7});

    // Counter wrap.
    force dut.r_stat_nic_frames = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.r_stat_nic_frames;
    @(negedge clk);
    check_val("wrap_preset", stat_nic, 32'hFFFF_FFFF);
    clear_logs();
    nic_q.push_back(mk_beat(0, 7, 0, 1));
    wait_out(1, "wrap");
    check_val("wrap_stat_nic", stat_nic, 32'd0);
    check_val("wrap_stat_psp", stat_psp, 32'd7);

    // Reset in the middle of a 6-beat NIC frame.
    clear_logs();
    for (int i = 0; i < 6; i++) nic_q.push_back(mk_beat(0, 8, i, 6));
    k = 0;
    while (in_log.size() < 2 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check_val("mid_busy", busy, 1'b1);
    rstn = 1'b0;
    nic_q.delete();
    #4;
    check_val("mid_rst_treadys", {nic_tready, psp_tready}, 2'b00);
    @(negedge clk);
    #4;
    check_val("mid_rst_tvalid", m_tvalid, 1'b0);
    check_val("mid_rst_busy", busy, 1'b0);
    check_val("mid_rst_stats", {stat_nic, stat_psp}, '0);
    @(negedge clk);
    rstn = 1'b1;
    clear_logs();
    psp_q.push_back(mk_beat(1, 9, 0, 1));
    for (int i = 0; i < 2; i++) nic_q.push_back(mk_beat(0, 9, i, 2));
    wait_out(3, "post_rst");
    check_val("post_rst_nic0", out_log[0], mk_beat(0, 9, 0, 2));
    check_val("post_rst_nic1", out_log[1], mk_beat(0, 9, 1, 2));
    check_val("post_rst_psp", out_log[2], mk_beat(1, 9, 0, 1));
    check_val("post_rst_stats", {stat_nic, stat_psp}, {32'd1, 32'd1});
    check_val("post_rst_idle", busy, 1'b0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
